// File: rtl/pe_sched_pkg.sv
// Shared widths, FSM encodings and default job sizes for the PE scheduler.
// Imported by the scheduler top and its per-PE result FIFO.
package pe_sched_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int CPLX_WIDTH = 2 * DATA_WIDTH;
  localparam int INST_WIDTH = 32;

  localparam int DEF_INST_NUM  = 16;
  localparam int DEF_LOAD_NUM  = 8;
  localparam int DEF_ALPHA_NUM = 4;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PROG = 3'd1;
  localparam logic [2:0] ST_LOAD = 3'd2;
  localparam logic [2:0] ST_RUN  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

endpackage

// File: rtl/sched_fifo.sv
// Per-PE result FIFO: one push and one pop per cycle, head read from the
// storage registers. A push while full is accepted only if a pop frees a slot.
module sched_fifo
  import pe_sched_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = CPLX_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // NOTE: non-blocking assignments make every flop sample pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: storage is not reset; the count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/pe_sched.sv
// PE job scheduler: broadcasts a program, distributes operands PE by PE and
// merges per-PE results round-robin into one output register.
module pe_sched
  import pe_sched_pkg::*;
#(
  parameter int NUM_PE     = 4,
  parameter int INST_NUM   = DEF_INST_NUM,
  parameter int LOAD_NUM   = DEF_LOAD_NUM,
  parameter int ALPHA_NUM  = DEF_ALPHA_NUM,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         inst_s_v,
  output logic                         inst_s_rdy,
  input  logic [INST_WIDTH-1:0]        inst_s,
  input  logic                         data_s_v,
  output logic                         data_s_rdy,
  input  logic [CPLX_WIDTH-1:0]        data_s,
  output logic                         inst_out_v,
  output logic [INST_WIDTH-1:0]        inst_out,
  output logic [NUM_PE-1:0]            pe_din_v,
  output logic [CPLX_WIDTH-1:0]        pe_din,
  input  logic [NUM_PE-1:0]            pe_dout_v,
  input  logic [NUM_PE*CPLX_WIDTH-1:0] pe_dout,
  output logic                         m_v,
  input  logic                         m_rdy,
  output logic [CPLX_WIDTH-1:0]        m_data,
  output logic [$clog2(NUM_PE)-1:0]    m_pe_id,
  output logic                         busy,
  output logic                         done,
  output logic                         ovf_err
);

  localparam int PE_ID_W = $clog2(NUM_PE);
  localparam int INST_CW = $clog2(INST_NUM + 1);
  localparam int LOAD_CW = $clog2(LOAD_NUM + 1);
  localparam int CNT_W   = $clog2(ALPHA_NUM + 1) + 1;

  logic [2:0]            state_q, state_d;
  logic [INST_CW-1:0]    inst_cnt_q, inst_cnt_d;
  logic [LOAD_CW-1:0]    load_cnt_q, load_cnt_d;
  logic [PE_ID_W-1:0]    pe_sel_q, pe_sel_d;
  logic                  inst_out_v_q, inst_out_v_d;
  logic [INST_WIDTH-1:0] inst_out_q, inst_out_d;
  logic [NUM_PE-1:0]     pe_din_v_q, pe_din_v_d;
  logic [CPLX_WIDTH-1:0] pe_din_q, pe_din_d;
  logic                  m_v_q, m_v_d;
  logic [CPLX_WIDTH-1:0] m_data_q, m_data_d;
  logic [PE_ID_W-1:0]    m_pe_id_q, m_pe_id_d;
  logic [PE_ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                  ovf_err_q, ovf_err_d;
  logic [CNT_W-1:0]      dcnt_q [NUM_PE];
  logic [CNT_W-1:0]      dcnt_d [NUM_PE];

  logic [CPLX_WIDTH-1:0] fifo_head [NUM_PE];
  logic [NUM_PE-1:0]     fifo_full, fifo_empty, fifo_pop, fifo_drop;
  logic                  inst_acc, data_acc, inst_last, load_last, pe_last;
  logic                  all_delivered, out_load, sel_found, deliver;
  logic [PE_ID_W-1:0]    sel_idx, cand;

  for (genvar g = 0; g < NUM_PE; g++) begin : g_fifo
    sched_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (CPLX_WIDTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (pe_dout_v[g]),
      .din   (pe_dout[CPLX_WIDTH*g +: CPLX_WIDTH]),
      .pop   (fifo_pop[g]),
      .head  (fifo_head[g]),
      .full  (fifo_full[g]),
      .empty (fifo_empty[g])
    );
  end

  // A full FIFO still takes a push in the cycle it is popped.
  assign fifo_drop = pe_dout_v & fifo_full & ~fifo_pop;

  assign inst_acc  = inst_s_v && (state_q == ST_PROG);
  assign data_acc  = data_s_v && (state_q == ST_LOAD);
  assign inst_last = (inst_cnt_q == INST_CW'(INST_NUM - 1));
  assign load_last = (load_cnt_q == LOAD_CW'(LOAD_NUM - 1));
  assign pe_last   = (pe_sel_q == PE_ID_W'(NUM_PE - 1));
  assign out_load  = !m_v_q || m_rdy;
  assign deliver   = m_v_q && m_rdy;

  always_comb begin
    all_delivered = 1'b1;
    for (int i = 0; i < NUM_PE; i++) begin
      if (dcnt_q[i] != CNT_W'(ALPHA_NUM)) all_delivered = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    inst_cnt_d = inst_cnt_q;
    load_cnt_d = load_cnt_q;
    pe_sel_d   = pe_sel_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_PROG;
      ST_PROG: begin
        if (inst_acc) begin
          if (inst_last) begin
            inst_cnt_d = '0;
            state_d    = ST_LOAD;
          end else begin
            inst_cnt_d = inst_cnt_q + 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (data_acc) begin
          if (load_last) begin
            load_cnt_d = '0;
            if (pe_last) begin
              pe_sel_d = '0;
              state_d  = ST_RUN;
            end else begin
              pe_sel_d = pe_sel_q + 1'b1;
            end
          end else begin
            load_cnt_d = load_cnt_q + 1'b1;
          end
        end
      end
      ST_RUN:  if (all_delivered) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    inst_out_v_d = inst_acc;
    inst_out_d   = inst_acc ? inst_s : inst_out_q;
    pe_din_v_d   = data_acc ? (NUM_PE'(1) << pe_sel_q) : '0;
    pe_din_d     = data_acc ? data_s : pe_din_q;
  end

  // Round-robin pick: first non-empty FIFO at or after rr_ptr.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_PE; k++) begin
      cand = PE_ID_W'((int'(rr_ptr_q) + k) % NUM_PE);
      if (!sel_found && !fifo_empty[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    fifo_pop  = '0;
    m_v_d     = m_v_q;
    m_data_d  = m_data_q;
    m_pe_id_d = m_pe_id_q;
    rr_ptr_d  = rr_ptr_q;
    if (out_load) begin
      m_v_d = sel_found;
      if (sel_found) begin
        fifo_pop  = NUM_PE'(1) << sel_idx;
        m_data_d  = fifo_head[sel_idx];
        m_pe_id_d = sel_idx;
        rr_ptr_d  = (sel_idx == PE_ID_W'(NUM_PE - 1)) ? '0 : sel_idx + 1'b1;
      end
    end
  end

  always_comb begin
    ovf_err_d = ovf_err_q | (|fifo_drop);
    for (int i = 0; i < NUM_PE; i++) begin
      dcnt_d[i] = dcnt_q[i];
      if (state_q == ST_DONE) begin
        dcnt_d[i] = '0;
      end else if (deliver && (m_pe_id_q == PE_ID_W'(i)) && (dcnt_q[i] != '1)) begin
        dcnt_d[i] = dcnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      inst_cnt_q   <= '0;
      load_cnt_q   <= '0;
      pe_sel_q     <= '0;
      inst_out_v_q <= 1'b0;
      inst_out_q   <= '0;
      pe_din_v_q   <= '0;
      pe_din_q     <= '0;
      m_v_q        <= 1'b0;
      m_data_q     <= '0;
      m_pe_id_q    <= '0;
      rr_ptr_q     <= '0;
      ovf_err_q    <= 1'b0;
      for (int i = 0; i < NUM_PE; i++) dcnt_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      inst_cnt_q   <= inst_cnt_d;
      load_cnt_q   <= load_cnt_d;
      pe_sel_q     <= pe_sel_d;
      inst_out_v_q <= inst_out_v_d;
      inst_out_q   <= inst_out_d;
      pe_din_v_q   <= pe_din_v_d;
      pe_din_q     <= pe_din_d;
      m_v_q        <= m_v_d;
      m_data_q     <= m_data_d;
      m_pe_id_q    <= m_pe_id_d;
      rr_ptr_q     <= rr_ptr_d;
      ovf_err_q    <= ovf_err_d;
      for (int i = 0; i < NUM_PE; i++) dcnt_q[i] <= dcnt_d[i];
    end
  end

  assign inst_s_rdy = (state_q == ST_PROG);
  assign data_s_rdy = (state_q == ST_LOAD);
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign inst_out_v = inst_out_v_q;
  assign inst_out   = inst_out_q;
  assign pe_din_v   = pe_din_v_q;
  assign pe_din     = pe_din_q;
  assign m_v        = m_v_q;
  assign m_data     = m_data_q;
  assign m_pe_id    = m_pe_id_q;
  assign ovf_err    = ovf_err_q;

endmodule

// File: tb/tb_pe_sched.sv
// Bench for pe_sched: directed jobs, overflow and mid-job reset, plus random
// jobs, all compared every cycle against a queue-based job model.
module tb_pe_sched;

  localparam int N     = 4;
  localparam int INUM  = 4;
  localparam int LNUM  = 2;
  localparam int ANUM  = 2;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst, start, inst_s_v, data_s_v, m_rdy;
  logic [31:0]    inst_s, data_s;
  logic [N-1:0]   pe_dout_v;
  logic [N*32-1:0] pe_dout;
  logic           inst_s_rdy, data_s_rdy, inst_out_v, m_v, busy, done, ovf_err;
  logic [31:0]    inst_out, pe_din, m_data;
  logic [N-1:0]   pe_din_v;
  logic [1:0]     m_pe_id;

  pe_sched #(
    .NUM_PE(N), .INST_NUM(INUM), .LOAD_NUM(LNUM), .ALPHA_NUM(ANUM), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .inst_s_v(inst_s_v), .inst_s_rdy(inst_s_rdy), .inst_s(inst_s),
    .data_s_v(data_s_v), .data_s_rdy(data_s_rdy), .data_s(data_s),
    .inst_out_v(inst_out_v), .inst_out(inst_out),
    .pe_din_v(pe_din_v), .pe_din(pe_din),
    .pe_dout_v(pe_dout_v), .pe_dout(pe_dout),
    .m_v(m_v), .m_rdy(m_rdy), .m_data(m_data), .m_pe_id(m_pe_id),
    .busy(busy), .done(done), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Job model: whole-job counters and one queue per PE result buffer.
  typedef enum int {M_IDLE, M_PROG, M_LOAD, M_RUN, M_DONE} mstate_e;
  mstate_e      ms;
  int           n_inst, n_data, rr;
  int           cnt [N];
  logic [31:0]  fq [N][$];
  bit           e_m_v, e_inst_v, e_ovf;
  logic [31:0]  e_m_data, e_inst, e_din;
  int           e_m_id;
  logic [N-1:0] e_din_v;

  task automatic model_reset();
    ms = M_IDLE; n_inst = 0; n_data = 0; rr = 0;
    for (int i = 0; i < N; i++) begin cnt[i] = 0; fq[i].delete(); end
    e_m_v = 0; e_inst_v = 0; e_ovf = 0;
    e_m_data = '0; e_inst = '0; e_din = '0; e_m_id = 0; e_din_v = '0;
  endtask

  task automatic model_step();
    bit all_in;
    bit found;
    if (rst) begin model_reset(); return; end
    all_in = 1;
    for (int i = 0; i < N; i++) if (cnt[i] != ANUM) all_in = 0;
    if (e_m_v && m_rdy) cnt[e_m_id]++;
    if (!e_m_v || m_rdy) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (rr + k) % N;
        if (!found && fq[idx].size() > 0) begin
          found = 1; e_m_data = fq[idx].pop_front(); e_m_id = idx; rr = (idx + 1) % N;
        end
      end
      e_m_v = found;
    end
    for (int i = 0; i < N; i++) begin
      if (pe_dout_v[i]) begin
        if (fq[i].size() < DEPTH) fq[i].push_back(pe_dout[32*i +: 32]);
        else e_ovf = 1;
      end
    end
    e_inst_v = 0;
    e_din_v  = '0;
    case (ms)
      M_IDLE: if (start) begin ms = M_PROG; n_inst = 0; end
      M_PROG: if (inst_s_v) begin
        e_inst_v = 1; e_inst = inst_s; n_inst++;
        if (n_inst == INUM) begin ms = M_LOAD; n_data = 0; end
      end
      M_LOAD: if (data_s_v) begin
        e_din = data_s; e_din_v = N'(1) << (n_data / LNUM); n_data++;
        if (n_data == N * LNUM) ms = M_RUN;
      end
      M_RUN:  if (all_in) ms = M_DONE;
      M_DONE: begin
        for (int i = 0; i < N; i++) cnt[i] = 0;
        ms = M_IDLE;
      end
      default: ms = M_IDLE;
    endcase
  endtask

  task automatic compare();
    check("busy", 64'(busy), 64'(ms != M_IDLE));
    check("done", 64'(done), 64'(ms == M_DONE));
    check("inst_rdy", 64'(inst_s_rdy), 64'(ms == M_PROG));
    check("data_rdy", 64'(data_s_rdy), 64'(ms == M_LOAD));
    check("inst_out_v", 64'(inst_out_v), 64'(e_inst_v));
    if (e_inst_v) check("inst_out", 64'(inst_out), 64'(e_inst));
    check("pe_din_v", 64'(pe_din_v), 64'(e_din_v));
    if (e_din_v != '0) check("pe_din", 64'(pe_din), 64'(e_din));
    check("m_v", 64'(m_v), 64'(e_m_v));
    if (e_m_v) begin
      check("m_data", 64'(m_data), 64'(e_m_data));
      check("m_pe_id", 64'(m_pe_id), 64'(e_m_id));
    end
    check("ovf_err", 64'(ovf_err), 64'(e_ovf));
  endtask

  bit          acc_inst, acc_data, rand_mode;
  int          n_done, stall_left;
  int          res_left [N];
  int          em_id [$];
  logic [31:0] em_data [$];

  task automatic tick();
    acc_inst = inst_s_v && inst_s_rdy;
    acc_data = data_s_v && data_s_rdy;
    if (m_v && m_rdy) begin em_id.push_back(int'(m_pe_id)); em_data.push_back(m_data); end
    @(posedge clk);
    model_step();
    #1;
    compare();
    if (done) n_done++;
  endtask

  // Result-side stimulus: random PE pushes / back-pressure, or a stall countdown.
  task automatic drive_bg();
    pe_dout_v = '0;
    if (rand_mode) begin
      m_rdy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (res_left[i] > 0 && $urandom_range(0, 3) == 0) begin
          pe_dout_v[i] = 1'b1;
          pe_dout[32*i +: 32] = $urandom;
          res_left[i]--;
        end
      end
    end else begin
      m_rdy = (stall_left == 0);
      if (stall_left > 0) stall_left--;
    end
  endtask

  task automatic do_reset();
    rst = 1; start = 0; inst_s_v = 0; data_s_v = 0; inst_s = '0; data_s = '0;
    rand_mode = 0; stall_left = 0;
    drive_bg();
    tick();
    rst = 0;
  endtask

  task automatic wait_done();
    int d0;
    int guard;
    d0 = n_done;
    guard = 0;
    while (n_done == d0 && guard < 400) begin drive_bg(); tick(); guard++; end
    check("job_done", 64'(n_done - d0), 64'(1));
    drive_bg();
    tick();
    check("busy_after_done", 64'(busy), 64'(0));
  endtask

  task automatic load_program(input bit rnd);
    int idx;
    int guard;
    idx = 0; guard = 0;
    while (idx < INUM && guard < 200) begin
      drive_bg();
      inst_s_v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      inst_s   = rnd ? $urandom : 32'hA0 + idx;
      tick();
      if (acc_inst) idx++;
      guard++;
    end
    inst_s_v = 0;
    check("prog_accepts", 64'(idx), 64'(INUM));
    check("state_load", 64'(data_s_rdy), 64'(1));
  endtask

  task automatic load_data(input bit rnd, input int stop_at);
    int idx;
    int guard;
    bit tog;
    idx = 0; guard = 0; tog = 1;
    while (idx < stop_at && guard < 200) begin
      drive_bg();
      data_s_v = rnd ? 1'($urandom_range(0, 1)) : tog;
      data_s   = rnd ? $urandom : 32'h10 + idx;
      tog = !tog;
      tick();
      if (acc_data) idx++;
      guard++;
    end
    data_s_v = 0;
    check("data_accepts", 64'(idx), 64'(stop_at));
  endtask

  task automatic run_directed(input int stall);
    rand_mode = 0; stall_left = 0;
    drive_bg(); start = 1; tick(); start = 0;
    load_program(0);
    load_data(0, N * LNUM);
    check("state_run_busy", 64'(busy), 64'(1));
    check("state_run_rdy", 64'({inst_s_rdy, data_s_rdy}), 64'(0));
    em_id.delete(); em_data.delete();
    stall_left = stall;
    for (int k = 0; k < 2; k++) begin
      drive_bg();
      pe_dout_v = '1;
      for (int i = 0; i < N; i++) pe_dout[32*i +: 32] = i * 16 + k;
      tick();
    end
    wait_done();
    check("n_emitted", 64'(em_id.size()), 64'(8));
    for (int j = 0; j < 8 && j < em_id.size(); j++) begin
      check("emit_id", 64'(em_id[j]), 64'(j % 4));
      check("emit_data", 64'(em_data[j]), 64'((j % 4) * 16 + j / 4));
    end
    if (stall > 0) check("no_ovf_after_stall", 64'(ovf_err), 64'(0));
  endtask

  task automatic run_random();
    rand_mode = 1;
    for (int i = 0; i < N; i++) res_left[i] = ANUM;
    drive_bg(); start = 1; tick(); start = 0;
    load_program(1);
    load_data(1, N * LNUM);
    wait_done();
    rand_mode = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_done = 0;
    pe_dout = '0;
    do_reset();
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_rdy", 64'({inst_s_rdy, data_s_rdy}), 64'(0));
    check("rst_inst_out", 64'({inst_out_v, inst_out}), 64'(0));
    check("rst_pe_din", 64'({pe_din_v, pe_din}), 64'(0));
    check("rst_m_out", 64'({m_v, m_pe_id, m_data}), 64'(0));
    check("rst_ovf", 64'(ovf_err), 64'(0));

    run_directed(0);
    run_directed(10);
    repeat (4) run_random();

    // One word parked in the output register, then PE 2 overfills its FIFO.
    do_reset();
    em_id.delete(); em_data.delete();
    stall_left = 1000;
    drive_bg(); pe_dout_v = 4'b0001; pe_dout[31:0] = 32'hF0; tick();
    drive_bg(); tick();
    for (int k = 0; k < 5; k++) begin
      drive_bg();
      pe_dout_v = 4'b0100;
      pe_dout[95:64] = 32'h20 + k;
      tick();
      if (k == 3) check("ovf_before_5th", 64'(ovf_err), 64'(0));
      if (k == 4) check("ovf_on_5th", 64'(ovf_err), 64'(1));
    end
    stall_left = 0;
    repeat (8) begin drive_bg(); tick(); end
    check("ovf_n_emitted", 64'(em_id.size()), 64'(5));
    for (int j = 0; j < 5 && j < em_id.size(); j++) begin
      check("ovf_emit_id", 64'(em_id[j]), 64'(j == 0 ? 0 : 2));
      check("ovf_emit_data", 64'(em_data[j]), 64'(j == 0 ? 32'hF0 : 32'h20 + j - 1));
    end
    check("ovf_sticky", 64'(ovf_err), 64'(1));

    // Abort mid-LOAD after three operands, then run a clean job.
    do_reset();
    drive_bg(); start = 1; tick(); start = 0;
    load_program(0);
    load_data(0, 3);
    rst = 1; drive_bg(); tick(); rst = 0;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_rdy", 64'({inst_s_rdy, data_s_rdy}), 64'(0));
    check("abort_pe_din_v", 64'(pe_din_v), 64'(0));
    run_directed(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
